// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared definitions for the reset sequencer slice: the sequencer state
// encoding, the reset-cause codes reported when RESET_SEQ_CAUSE_EN is
// defined, and a small helper used to size counters.
// Ports: none (package).

package reset_seq_pkg;

    // HOLD keeps every domain in reset, RELEASE walks the domains out of
    // reset one at a time, DONE means every domain is running.
    typedef enum logic [1:0] {
        SEQ_HOLD    = 2'd0,
        SEQ_RELEASE = 2'd1,
        SEQ_DONE    = 2'd2
    } seq_state_t;

    // Reset-cause codes.
    localparam logic [1:0] CAUSE_RST  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// reset_sync_chain
// Multi-flop synchroniser for an asynchronous level signal. On rst every
// stage clears to 0, so an active-low request looks asserted until the chain
// has filled with real samples.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (clears all stages to 0)
//   d    - asynchronous input
//   q    - synchronised output (last stage)

module reset_sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("reset_sync_chain: DEPTH must be 2 or more");
        end
    endgenerate

    logic [DEPTH-1:0] stages;

    // Shift register: the sample enters stage 0 and reaches the output
    // DEPTH-1 edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Holds all reset domains in reset while any request is active, keeps them
// held for HOLD_CYCLES quiet cycles after the last request, then releases
// them one per GAP_CYCLES in ascending order. Any new request (or rst)
// reasserts every domain on the same edge.
// Optional feature: define RESET_SEQ_CAUSE_EN to add the rst_cause output
// (00 = rst, 01 = external request, 10 = soft request).
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   ext_rst_req_n  - asynchronous active-low external reset request
//   soft_rst_req   - clk-synchronous active-high soft reset request
//   rst_out_n      - per-domain active-low resets, bit 0 released first
//   seq_done       - high when every domain is released
//   rst_cause      - (RESET_SEQ_CAUSE_EN only) cause of the latest reset

module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ext_rst_req_n,
    input  logic                soft_rst_req,
    output logic [CHANNELS-1:0] rst_out_n,
    output logic                seq_done
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]          rst_cause
`endif
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IDX_W = $clog2(CHANNELS + 1);

    generate
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("reset_sequencer: CHANNELS must be in 1..16");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_sequencer: SYNC_STAGES must be 2 or more");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_sequencer: HOLD_CYCLES must be 1 or more");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("reset_sequencer: GAP_CYCLES must be 1 or more");
        end
    endgenerate

    logic ext_sync;
    logic ext_active;
    logic req_active;

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [IDX_W-1:0] index, index_next;

    logic [CHANNELS-1:0] rst_out_n_next;
    logic                seq_done_next;

    reset_sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_rst_req_n),
        .q   (ext_sync)
    );

    assign ext_active = ~ext_sync;
    assign req_active = ext_active | soft_rst_req;

    // State register. Outputs are registered so every domain sees a clean,
    // glitch-free reset line; on rst everything returns to the fully held
    // state on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_HOLD;
            counter   <= '0;
            index     <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            index     <= index_next;
            rst_out_n <= rst_out_n_next;
            seq_done  <= seq_done_next;
        end
    end

    // Next-state logic. A request overrides everything and restarts the
    // hold window; the one counter times both the hold window and the gaps
    // between channel releases.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        index_next   = index;
        if (req_active) begin
            state_next   = SEQ_HOLD;
            counter_next = '0;
            index_next   = '0;
        end else begin
            case (state)
                SEQ_HOLD: begin
                    if (counter == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_next   = SEQ_RELEASE;
                        counter_next = '0;
                        index_next   = '0;
                    end else begin
                        counter_next = counter + CNT_W'(1);
                    end
                end
                SEQ_RELEASE: begin
                    if (counter == CNT_W'(GAP_CYCLES - 1)) begin
                        counter_next = '0;
                        index_next   = index + IDX_W'(1);
                        if (index == IDX_W'(CHANNELS - 1)) begin
                            state_next = SEQ_DONE;
                        end
                    end else begin
                        counter_next = counter + CNT_W'(1);
                    end
                end
                SEQ_DONE: begin
                    state_next = SEQ_DONE;
                end
                default: begin
                    state_next   = SEQ_HOLD;
                    counter_next = '0;
                    index_next   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state: in RELEASE the channels below the
    // index are out of reset, so the release of a channel and the index
    // increment land on the same edge.
    always_comb begin
        rst_out_n_next = '0;
        seq_done_next  = (state_next == SEQ_DONE);
        for (int i = 0; i < CHANNELS; i++) begin
            rst_out_n_next[i] = (state_next == SEQ_DONE) ||
                                ((state_next == SEQ_RELEASE) && (IDX_W'(i) < index_next));
        end
    end

`ifdef RESET_SEQ_CAUSE_EN
    // Cause register: refreshed on every edge a request is active, external
    // taking priority over soft, and held while the system is quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cause <= CAUSE_RST;
        end else if (ext_active) begin
            rst_cause <= CAUSE_EXT;
        end else if (soft_rst_req) begin
            rst_cause <= CAUSE_SOFT;
        end
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer. The stimulus process drives one edge
// at a time and pushes the expected outputs for that edge; a monitor pops one
// entry after each rising edge and compares. The reference model works from
// the timing rules alone: it remembers the edge of the last active request
// and derives how many channels should be out of reset from the elapsed time.

module tb_reset_sequencer;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic          clk;
    logic          rst;
    logic          ext_rst_req_n;
    logic          soft_rst_req;
    logic [CH-1:0] rst_out_n;
    logic          seq_done;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]    rst_cause;
`endif

    reset_sequencer #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
`ifdef RESET_SEQ_CAUSE_EN
        .rst_cause     (rst_cause),
`endif
        .clk           (clk),
        .rst           (rst),
        .ext_rst_req_n (ext_rst_req_n),
        .soft_rst_req  (soft_rst_req),
        .rst_out_n     (rst_out_n),
        .seq_done      (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        logic [CH-1:0] rst_out_n;
        logic          done;
        logic [1:0]    cause;
    } exp_t;

    exp_t exp_q[$];
    logic ext_hist[$];

    int vectors;
    int miscompares;

    int edge_num;
    int last_req_edge;
    int rst_edge;
    logic [1:0] model_cause;

    // Drive one clock edge worth of inputs and push the model's prediction
    // for the outputs right after that edge.
    task automatic applyStimulus(input logic r, input logic s, input logic e_n);
        exp_t x;
        bit   ext_act;
        bit   req;
        int   elapsed;
        int   released;
        @(negedge clk);
        rst          = r;
        soft_rst_req = s;
        #($urandom_range(1, 4));
        ext_rst_req_n = e_n;

        ext_hist.push_back(e_n);
        if (r) begin
            rst_edge      = edge_num;
            last_req_edge = edge_num;
            model_cause   = 2'b00;
        end else begin
            if (edge_num - rst_edge <= SYNC)
                ext_act = 1'b1;
            else
                ext_act = (ext_hist[edge_num - SYNC] == 1'b0);
            req = ext_act || s;
            if (req) last_req_edge = edge_num;
            if (ext_act)  model_cause = 2'b01;
            else if (s)   model_cause = 2'b10;
        end

        elapsed = edge_num - last_req_edge;
        if (elapsed < HOLD) released = 0;
        else                released = (elapsed - HOLD) / GAP;
        if (released > CH) released = CH;

        x.edge_no   = edge_num;
        x.rst_out_n = CH'((1 << released) - 1);
        x.done      = (released == CH);
        x.cause     = model_cause;
        exp_q.push_back(x);
        edge_num++;
    endtask

    task automatic checkOutput(input exp_t x);
        vectors++;
        if (rst_out_n !== x.rst_out_n || seq_done !== x.done) begin
            miscompares++;
            $display("[TB] FAIL outputs edge %0d: got rst_out_n=%b seq_done=%b, want rst_out_n=%b seq_done=%b",
                     x.edge_no, rst_out_n, seq_done, x.rst_out_n, x.done);
        end
`ifdef RESET_SEQ_CAUSE_EN
        vectors++;
        if (rst_cause !== x.cause) begin
            miscompares++;
            $display("[TB] FAIL rst_cause edge %0d: got %b, want %b", x.edge_no, rst_cause, x.cause);
        end
`endif
    endtask

    // Monitor: one prediction is consumed per rising edge, sampled just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int ext_low_left;
        logic r, s, e_n;

        vectors       = 0;
        miscompares   = 0;
        edge_num      = 0;
        last_req_edge = 0;
        rst_edge      = 0;
        model_cause   = 2'b00;
        rst           = 1'b1;
        soft_rst_req  = 1'b0;
        ext_rst_req_n = 1'b1;

        $display("[TB] power-up sequence");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        idle(40);

        $display("[TB] soft pulse while done");
        applyStimulus(1'b0, 1'b1, 1'b1);
        idle(40);

        $display("[TB] external request for 10 cycles");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        idle(45);

        $display("[TB] soft pulse right after channel 1 release");
        applyStimulus(1'b0, 1'b1, 1'b1);
        idle(HOLD + 2 * GAP);
        applyStimulus(1'b0, 1'b1, 1'b1);
        idle(40);

        $display("[TB] one-cycle rst while done");
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle(40);

        $display("[TB] soft and external together");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        idle(45);

        $display("[TB] randomized traffic");
        ext_low_left = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 599) == 0);
            s = ($urandom_range(0, 119) == 0);
            if (ext_low_left > 0) begin
                e_n = 1'b0;
                ext_low_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                e_n = 1'b0;
                ext_low_left = $urandom_range(0, 11);
            end else begin
                e_n = 1'b1;
            end
            applyStimulus(r, s, e_n);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
